// File: rtl/dm_port_arbiter_pkg.sv
// Shared constants for the data-memory port arbiter: FSM encodings,
// byte-enable shorthands and a word-alignment helper.
package dm_port_arbiter_pkg;

  localparam logic [0:0] ARB_IDLE      = 1'b0;
  localparam logic [0:0] ARB_DMA_BURST = 1'b1;

  localparam logic [3:0] BE_NONE = 4'b0000;
  localparam logic [3:0] BE_WORD = 4'b1111;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/dm_port_arbiter_if.sv
// Bundle of the CPU, DMA and DM-side signals around the shared DM port.
// The arbiter uses the slave view; requesters and memory use the master view.
interface dm_port_arbiter_if;

  logic        cpu_req;
  logic [3:0]  cpu_byte_en;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic        cpu_gnt;
  logic        cpu_stall;
  logic [31:0] cpu_rdata;

  logic        dma_req;
  logic [3:0]  dma_byte_en;
  logic [31:0] dma_addr;
  logic [31:0] dma_wdata;
  logic        dma_last;
  logic        dma_gnt;
  logic        dma_rvalid;
  logic [31:0] dma_rdata;

  logic        dm_en;
  logic [3:0]  dm_byte_en;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic [31:0] dm_rdata;

  modport slave (
    input  cpu_req, cpu_byte_en, cpu_addr, cpu_wdata,
    output cpu_gnt, cpu_stall, cpu_rdata,
    input  dma_req, dma_byte_en, dma_addr, dma_wdata, dma_last,
    output dma_gnt, dma_rvalid, dma_rdata,
    output dm_en, dm_byte_en, dm_addr, dm_wdata,
    input  dm_rdata
  );

  modport master (
    output cpu_req, cpu_byte_en, cpu_addr, cpu_wdata,
    input  cpu_gnt, cpu_stall, cpu_rdata,
    output dma_req, dma_byte_en, dma_addr, dma_wdata, dma_last,
    input  dma_gnt, dma_rvalid, dma_rdata,
    input  dm_en, dm_byte_en, dm_addr, dm_wdata,
    output dm_rdata
  );

endinterface

// File: rtl/dm_arb_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module dm_arb_counter #(
  parameter int MAX   = 4,
  parameter int WIDTH = $clog2(MAX + 2)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MAX);

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      count <= '0;
    end else if (inc && (count != MAX_VAL)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/dm_port_arbiter.sv
// Shares the single DM port between the M stage and the DMA engine:
// CPU priority, bounded DMA starvation via wait_cnt, bounded DMA bursts via beat_cnt.
module dm_port_arbiter
  import dm_port_arbiter_pkg::*;
#(
  parameter int MAX_WAIT  = 4,
  parameter int MAX_BURST = 8
) (
  input logic               clk,
  input logic               reset,
  dm_port_arbiter_if.slave  bus
);

  localparam int WAIT_W = $clog2(MAX_WAIT + 2);
  localparam int BEAT_W = $clog2(MAX_BURST + 1);
  localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MAX_WAIT);
  localparam logic [BEAT_W-1:0] BEAT_LIMIT = BEAT_W'(MAX_BURST - 1);
  localparam logic BURST_OK = (MAX_BURST > 1);

  logic [0:0]        state;
  logic [0:0]        state_nxt;
  logic [WAIT_W-1:0] wait_cnt;
  logic [BEAT_W-1:0] beat_cnt;
  logic              in_idle;
  logic              dma_sel;
  logic              cpu_gnt_c;
  logic              dma_gnt_c;
  logic              burst_start;
  logic              burst_end;
  logic              wait_clr;
  logic              wait_inc;
  logic              beat_clr;
  logic              beat_inc;

  assign in_idle = (state == ARB_IDLE);

  // Grants are forced low while reset is high so DM never sees a stray access.
  always_comb begin
    state_nxt   = state;
    dma_sel     = 1'b0;
    cpu_gnt_c   = 1'b0;
    dma_gnt_c   = 1'b0;
    burst_start = 1'b0;
    burst_end   = 1'b0;
    if (!reset) begin
      if (in_idle) begin
        dma_sel     = bus.dma_req & (~bus.cpu_req | (wait_cnt == WAIT_LIMIT));
        cpu_gnt_c   = bus.cpu_req & ~dma_sel;
        dma_gnt_c   = dma_sel;
        burst_start = dma_sel & ~bus.dma_last & BURST_OK;
        if (burst_start) state_nxt = ARB_DMA_BURST;
      end else begin
        dma_gnt_c = bus.dma_req;
        burst_end = dma_gnt_c & (bus.dma_last | (beat_cnt == BEAT_LIMIT));
        if (burst_end) state_nxt = ARB_IDLE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state <= ARB_IDLE;
    else       state <= state_nxt;
  end

  // Inside a burst every cycle either grants or bubbles, so wait_cnt stays cleared.
  assign wait_clr = dma_gnt_c | ~bus.dma_req;
  assign wait_inc = bus.dma_req & ~dma_gnt_c;

  // Beat count is 0 in IDLE; the first granted beat of a burst makes it 1.
  assign beat_clr = in_idle ? ~burst_start : burst_end;
  assign beat_inc = in_idle ? burst_start : (dma_gnt_c & ~burst_end);

  dm_arb_counter #(.MAX(MAX_WAIT), .WIDTH(WAIT_W)) u_wait_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (wait_clr),
    .inc   (wait_inc),
    .count (wait_cnt)
  );

  dm_arb_counter #(.MAX(MAX_BURST - 1), .WIDTH(BEAT_W)) u_beat_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (beat_clr),
    .inc   (beat_inc),
    .count (beat_cnt)
  );

  always_comb begin
    bus.dm_en      = cpu_gnt_c | dma_gnt_c;
    bus.dm_addr    = '0;
    bus.dm_wdata   = '0;
    bus.dm_byte_en = BE_NONE;
    if (dma_gnt_c) begin
      bus.dm_addr    = word_align(bus.dma_addr);
      bus.dm_wdata   = bus.dma_wdata;
      bus.dm_byte_en = bus.dma_byte_en;
    end else if (cpu_gnt_c) begin
      bus.dm_addr    = bus.cpu_addr;
      bus.dm_wdata   = bus.cpu_wdata;
      bus.dm_byte_en = bus.cpu_byte_en;
    end
  end

  assign bus.cpu_gnt   = cpu_gnt_c;
  assign bus.dma_gnt   = dma_gnt_c;
  assign bus.cpu_stall = bus.cpu_req & ~cpu_gnt_c & ~reset;
  assign bus.cpu_rdata = reset ? 32'h0 : bus.dm_rdata;

  always_ff @(posedge clk) begin
    if (reset) begin
      bus.dma_rvalid <= 1'b0;
      bus.dma_rdata  <= 32'h0;
    end else begin
      bus.dma_rvalid <= dma_gnt_c & (bus.dma_byte_en == BE_NONE);
      if (dma_gnt_c && (bus.dma_byte_en == BE_NONE)) begin
        bus.dma_rdata <= bus.dm_rdata;
      end
    end
  end

endmodule

// File: tb/tb_dm_port_arbiter.sv
// Self-checking bench for dm_port_arbiter: fixed grant timelines plus a
// scoreboard of expected read data for CPU loads and DMA reads.
module tb_dm_port_arbiter;
  import dm_port_arbiter_pkg::*;

  logic clk;
  logic reset;
  logic reset_drv;

  int assertions;
  int failures;

  logic [31:0] cpu_q[$];
  logic [31:0] dma_q[$];
  logic [31:0] mem [0:255];

  dm_port_arbiter_if bus ();

  dm_port_arbiter #(.MAX_WAIT(4), .MAX_BURST(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Word-addressed DM model: combinational read, byte-lane write at the grant edge.
  assign bus.dm_rdata = mem[bus.dm_addr[9:2]];

  always @(posedge clk) begin
    if (bus.dm_en) begin
      for (int b = 0; b < 4; b++) begin
        if (bus.dm_byte_en[b]) mem[bus.dm_addr[9:2]][8*b +: 8] <= bus.dm_wdata[8*b +: 8];
      end
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    assertions++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic c_req, input logic [3:0] c_be,
                               input logic [31:0] c_addr, input logic [31:0] c_wd,
                               input logic d_req, input logic [3:0] d_be,
                               input logic [31:0] d_addr, input logic [31:0] d_wd,
                               input logic d_last);
    @(posedge clk);
    #1;
    reset           = reset_drv;
    bus.cpu_req     = c_req;
    bus.cpu_byte_en = c_be;
    bus.cpu_addr    = c_addr;
    bus.cpu_wdata   = c_wd;
    bus.dma_req     = d_req;
    bus.dma_byte_en = d_be;
    bus.dma_addr    = d_addr;
    bus.dma_wdata   = d_wd;
    bus.dma_last    = d_last;
    @(negedge clk);
  endtask

  task automatic idleCycle();
    applyStimulus(1'b0, BE_NONE, 32'h0, 32'h0, 1'b0, BE_NONE, 32'h0, 32'h0, 1'b0);
  endtask

  // Scoreboard: read data is compared whenever the DUT presents it.
  always @(negedge clk) begin
    if (!reset && bus.cpu_gnt && bus.cpu_byte_en == BE_NONE) begin
      if (cpu_q.size() == 0) checkOutput("cpu_load_unexpected", 32'h1, 32'h0);
      else checkOutput("cpu_rdata_sb", bus.cpu_rdata, cpu_q.pop_front());
    end
    if (!reset && bus.dma_rvalid) begin
      if (dma_q.size() == 0) checkOutput("dma_rvalid_unexpected", 32'h1, 32'h0);
      else checkOutput("dma_rdata_sb", bus.dma_rdata, dma_q.pop_front());
    end
  end

  logic exp_dma;
  int   beat;

  initial begin
    assertions = 0;
    failures   = 0;
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    reset     = 1'b1;
    reset_drv = 1'b1;
    bus.cpu_req = 1'b0; bus.cpu_byte_en = BE_NONE; bus.cpu_addr = '0; bus.cpu_wdata = '0;
    bus.dma_req = 1'b0; bus.dma_byte_en = BE_NONE; bus.dma_addr = '0; bus.dma_wdata = '0;
    bus.dma_last = 1'b0;

    // Reset: requests present but nothing may be granted.
    applyStimulus(1'b1, BE_WORD, 32'h10, 32'h1, 1'b1, BE_WORD, 32'h20, 32'h2, 1'b1);
    applyStimulus(1'b1, BE_WORD, 32'h10, 32'h1, 1'b1, BE_WORD, 32'h20, 32'h2, 1'b1);
    checkOutput("rst_cpu_gnt", bus.cpu_gnt, 0);
    checkOutput("rst_dma_gnt", bus.dma_gnt, 0);
    checkOutput("rst_dm_en", bus.dm_en, 0);
    checkOutput("rst_stall", bus.cpu_stall, 0);
    checkOutput("rst_dma_rvalid", bus.dma_rvalid, 0);
    checkOutput("rst_dma_rdata", bus.dma_rdata, 0);
    reset_drv = 1'b0;
    idleCycle();
    checkOutput("idle_dm_en", bus.dm_en, 0);
    checkOutput("idle_dm_byte_en", bus.dm_byte_en, 0);

    // CPU store, load back, trap-masked store, load again.
    applyStimulus(1'b1, BE_WORD, 32'h10, 32'h1234_5678, 1'b0, BE_NONE, 32'h0, 32'h0, 1'b0);
    checkOutput("sw_cpu_gnt", bus.cpu_gnt, 1);
    checkOutput("sw_dm_en", bus.dm_en, 1);
    checkOutput("sw_dm_byte_en", bus.dm_byte_en, 32'hF);
    checkOutput("sw_dm_addr", bus.dm_addr, 32'h10);
    checkOutput("sw_dm_wdata", bus.dm_wdata, 32'h1234_5678);
    checkOutput("sw_stall", bus.cpu_stall, 0);
    cpu_q.push_back(32'h1234_5678);
    applyStimulus(1'b1, BE_NONE, 32'h10, 32'h0, 1'b0, BE_NONE, 32'h0, 32'h0, 1'b0);
    checkOutput("lw_cpu_gnt", bus.cpu_gnt, 1);
    checkOutput("lw_cpu_rdata", bus.cpu_rdata, 32'h1234_5678);
    applyStimulus(1'b1, BE_NONE, 32'h10, 32'hFFFF_FFFF, 1'b0, BE_NONE, 32'h0, 32'h0, 1'b0);
    checkOutput("masked_sw_gnt", bus.cpu_gnt, 1);
    checkOutput("masked_sw_be", bus.dm_byte_en, 0);
    cpu_q.push_back(32'h1234_5678);
    cpu_q.push_back(32'h1234_5678);
    applyStimulus(1'b1, BE_NONE, 32'h10, 32'h0, 1'b0, BE_NONE, 32'h0, 32'h0, 1'b0);
    applyStimulus(1'b1, BE_WORD, 32'h20, 32'hDEAD_BEEF, 1'b0, BE_NONE, 32'h0, 32'h0, 1'b0);
    idleCycle();

    // Contention: CPU wins cycles 0-3, DMA wins cycle 4, then wait_cnt restarts.
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'b1, BE_WORD, 32'h40, 32'(i), 1'b1, BE_WORD, 32'h47, 32'hA5A5_0000, 1'b1);
      exp_dma = (i == 4);
      checkOutput($sformatf("cont_dma_gnt_%0d", i), bus.dma_gnt, 32'(exp_dma));
      checkOutput($sformatf("cont_cpu_gnt_%0d", i), bus.cpu_gnt, 32'(!exp_dma));
      checkOutput($sformatf("cont_stall_%0d", i), bus.cpu_stall, 32'(exp_dma));
      if (exp_dma) checkOutput("cont_dm_addr_aligned", bus.dm_addr, 32'h44);
    end
    idleCycle();

    // 3-beat burst against a requesting CPU.
    for (int cyc = 0; cyc < 8; cyc++) begin
      beat = (cyc < 4) ? 1 : cyc - 3;
      applyStimulus(1'b1, BE_WORD, 32'h60, 32'h0, cyc < 7, BE_WORD,
                    32'h200 + 32'(beat << 2), 32'hB300_0000 + 32'(beat), cyc == 6);
      exp_dma = (cyc >= 4) && (cyc <= 6);
      checkOutput($sformatf("b3_dma_gnt_%0d", cyc), bus.dma_gnt, 32'(exp_dma));
      checkOutput($sformatf("b3_cpu_gnt_%0d", cyc), bus.cpu_gnt, 32'(!exp_dma));
      checkOutput($sformatf("b3_stall_%0d", cyc), bus.cpu_stall, 32'(exp_dma));
    end
    idleCycle();

    // 12-beat burst: forced release after beat 8, CPU gets 4 cycles, DMA resumes.
    beat = 1;
    for (int cyc = 0; cyc < 21; cyc++) begin
      applyStimulus(1'b1, BE_WORD, 32'h80, 32'hC000_0000 + 32'(cyc), beat <= 12, BE_WORD,
                    32'h100 + 32'(beat << 2), 32'hB000_0000 + 32'(beat), beat == 12);
      exp_dma = ((cyc >= 4) && (cyc <= 11)) || ((cyc >= 16) && (cyc <= 19));
      checkOutput($sformatf("b12_dma_gnt_%0d", cyc), bus.dma_gnt, 32'(exp_dma));
      checkOutput($sformatf("b12_cpu_gnt_%0d", cyc), bus.cpu_gnt, 32'(!exp_dma));
      if (exp_dma) begin
        checkOutput($sformatf("b12_dm_wdata_%0d", beat), bus.dm_wdata, 32'hB000_0000 + 32'(beat));
        beat++;
      end
    end
    idleCycle();

    // DMA read of 0x20: data arrives exactly one cycle after the grant.
    dma_q.push_back(32'hDEAD_BEEF);
    applyStimulus(1'b0, BE_NONE, 32'h0, 32'h0, 1'b1, BE_NONE, 32'h22, 32'h0, 1'b1);
    checkOutput("dmard_gnt", bus.dma_gnt, 1);
    checkOutput("dmard_dm_addr", bus.dm_addr, 32'h20);
    checkOutput("dmard_rvalid_early", bus.dma_rvalid, 0);
    idleCycle();
    checkOutput("dmard_rvalid", bus.dma_rvalid, 1);
    checkOutput("dmard_rdata", bus.dma_rdata, 32'hDEAD_BEEF);
    idleCycle();
    checkOutput("dmard_rvalid_clear", bus.dma_rvalid, 0);

    // Reset during burst beat 2; afterwards the pending CPU request is granted.
    applyStimulus(1'b0, BE_NONE, 32'h0, 32'h0, 1'b1, BE_WORD, 32'h300, 32'h1, 1'b0);
    checkOutput("rstb_beat1_gnt", bus.dma_gnt, 1);
    reset_drv = 1'b1;
    applyStimulus(1'b1, BE_WORD, 32'h90, 32'h5, 1'b1, BE_NONE, 32'h304, 32'h0, 1'b0);
    checkOutput("rstb_dma_gnt", bus.dma_gnt, 0);
    checkOutput("rstb_dm_en", bus.dm_en, 0);
    reset_drv = 1'b0;
    applyStimulus(1'b1, BE_WORD, 32'h90, 32'h5, 1'b1, BE_NONE, 32'h304, 32'h0, 1'b0);
    checkOutput("rstb_after_cpu_gnt", bus.cpu_gnt, 1);
    checkOutput("rstb_after_dma_gnt", bus.dma_gnt, 0);
    checkOutput("rstb_after_rvalid", bus.dma_rvalid, 0);
    idleCycle();
    idleCycle();

    checkOutput("sb_cpu_drained", 32'(cpu_q.size()), 0);
    checkOutput("sb_dma_drained", 32'(dma_q.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

endmodule
